// File: rtl/mont_io_bridge.sv
// mont_io_bridge: word-serial front end for the 1024-bit Montgomery multiplier.
// Collects A, B, M (least-significant word first) from a valid/ready input
// stream, fires the multiplier, captures its 1025-bit result and streams it
// back out as NW+1 words. Word/operand selection uses counter bit fields, so
// NW = OPW/DW must be a power of two (32 with the default sizes).
module mont_io_bridge #(
    parameter int DW  = 32,
    parameter int OPW = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic             s_last,
    output logic             mont_start,
    output logic [OPW-1:0]   mont_a,
    output logic [OPW-1:0]   mont_b,
    output logic [OPW-1:0]   mont_m,
    input  logic [OPW:0]     mont_result,
    input  logic             mont_done,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    output logic             busy,
    output logic             frame_err
);

    localparam int NW  = OPW / DW;
    localparam int WSW = $clog2(NW);        // word-within-operand index width
    localparam int KW  = $clog2(3 * NW);    // input word counter width (WSW + 2)
    localparam int JW  = $clog2(NW + 1);    // output word counter width (WSW + 1)
    localparam logic [KW-1:0] K_LAST = KW'(3 * NW - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NW);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [KW-1:0]   k_r;
    logic [JW-1:0]   j_r;
    logic [OPW-1:0]  mont_a_r;
    logic [OPW-1:0]  mont_b_r;
    logic [OPW-1:0]  mont_m_r;
    logic [OPW:0]    result_r;
    logic            frame_err_r;

    logic            in_hs_s;
    logic            k_last_s;
    logic            frame_ok_s;
    logic            frame_bad_s;
    logic            out_hs_s;
    logic            stream_end_s;
    logic [1:0]      op_sel_s;
    logic [WSW-1:0]  word_sel_s;

    // Handshake and framing decode for both streams.
    always_comb begin
        in_hs_s      = (state_r == S_LOAD) && s_valid;
        k_last_s     = (k_r == K_LAST);
        frame_ok_s   = in_hs_s && s_last && k_last_s;
        frame_bad_s  = in_hs_s && (s_last != k_last_s);
        out_hs_s     = (state_r == S_STREAM) && m_ready;
        stream_end_s = out_hs_s && (j_r == J_LAST);
        op_sel_s     = k_r[KW-1:WSW];
        word_sel_s   = k_r[WSW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= S_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; mont_done only matters while waiting on the core.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (frame_ok_s) state_s = S_START;
                else            state_s = S_LOAD;
            end
            S_START: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (mont_done) state_s = S_STREAM;
                else           state_s = S_WAIT;
            end
            S_STREAM: begin
                if (stream_end_s) state_s = S_LOAD;
                else              state_s = S_STREAM;
            end
            default: begin
                state_s = S_LOAD;
            end
        endcase
    end

    // Operand assembly, word counters, result capture and error flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            k_r         <= {KW{1'b0}};
            j_r         <= {JW{1'b0}};
            mont_a_r    <= {OPW{1'b0}};
            mont_b_r    <= {OPW{1'b0}};
            mont_m_r    <= {OPW{1'b0}};
            result_r    <= {(OPW+1){1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= frame_bad_s;

            // Misframed words are dropped; the final good word is kept.
            if (in_hs_s && !frame_bad_s) begin
                case (op_sel_s)
                    2'd0:    mont_a_r[DW*word_sel_s +: DW] <= s_data;
                    2'd1:    mont_b_r[DW*word_sel_s +: DW] <= s_data;
                    2'd2:    mont_m_r[DW*word_sel_s +: DW] <= s_data;
                    default: begin end
                endcase
            end

            // Word 3*NW-1 always ends the frame, good or bad.
            if (in_hs_s) begin
                if (k_last_s || s_last) k_r <= {KW{1'b0}};
                else                    k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
            end

            if ((state_r == S_WAIT) && mont_done) begin
                result_r <= mont_result;
                j_r      <= {JW{1'b0}};
            end else if (out_hs_s) begin
                if (stream_end_s) j_r <= {JW{1'b0}};
                else              j_r <= j_r + {{(JW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output word select; the top word carries only the result's carry bit.
    always_comb begin
        m_data = {DW{1'b0}};
        if (state_r == S_STREAM) begin
            if (j_r[JW-1]) m_data = {{(DW-1){1'b0}}, result_r[OPW]};
            else           m_data = result_r[DW*j_r[WSW-1:0] +: DW];
        end else begin
            m_data = {DW{1'b0}};
        end
    end

    assign s_ready    = (state_r == S_LOAD);
    assign mont_start = (state_r == S_START);
    assign busy       = (state_r != S_LOAD);
    assign m_valid    = (state_r == S_STREAM);
    assign m_last     = (state_r == S_STREAM) && (j_r == J_LAST);
    assign frame_err  = frame_err_r;
    assign mont_a     = mont_a_r;
    assign mont_b     = mont_b_r;
    assign mont_m     = mont_m_r;

endmodule

// File: tb/tb_mont_io_bridge.sv
// Directed self-checking bench for mont_io_bridge; the bench acts as the
// multiplier stub, driving mont_result/mont_done itself.
module tb_mont_io_bridge;

    logic          clk;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          s_last;
    logic          mont_start;
    logic [1023:0] mont_a;
    logic [1023:0] mont_b;
    logic [1023:0] mont_m;
    logic [1024:0] mont_result;
    logic          mont_done;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          m_last;
    logic          busy;
    logic          frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_ferr   = 0;

    mont_io_bridge dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: cycles with mont_start / frame_err high.
    always @(posedge clk) begin
        if (mont_start === 1'b1) n_start <= n_start + 1;
        if (frame_err === 1'b1)  n_ferr  <= n_ferr + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed low64 %h expected low64 %h (full 1024-bit compare)",
                   tag, obs[63:0], exp[63:0]);
        end
    endtask

    // Sends one frame. last_at = word carrying s_last (95 = good frame,
    // <95 = early s_last, <0 = no s_last at all). gap_len>0 idles after words 10 and 40.
    task automatic send_frame(input logic [1023:0] a, input logic [1023:0] b,
                              input logic [1023:0] m, input int last_at, input int gap_len);
        int nwords;
        int starts0;
        int ferr0;
        logic [1023:0] op;
        nwords  = (last_at >= 0 && last_at < 95) ? last_at + 1 : 96;
        starts0 = n_start;
        ferr0   = n_ferr;
        for (int k = 0; k < nwords; k++) begin
            int bud;
            op      = (k < 32) ? a : ((k < 64) ? b : m);
            s_data  = op[32*(k%32) +: 32];
            s_last  = (k == last_at);
            s_valid = 1'b1;
            bud = 50;
            while (s_ready !== 1'b1 && bud > 0) begin
                tick;
                bud--;
            end
            if (bud == 0) chk_b("s_ready_wait", s_ready, 1'b1);
            tick;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (gap_len > 0 && (k == 10 || k == 40)) repeat (gap_len) tick;
        end
        if (last_at == 95) begin
            chk_b("start_after_last", mont_start, 1'b1);
            chk_b("busy_at_start", busy, 1'b1);
            chk_b("s_ready_at_start", s_ready, 1'b0);
            chk_b("no_ferr_good", frame_err, 1'b0);
            tick;
            chk_b("start_one_cycle", mont_start, 1'b0);
            chk_b("busy_in_wait", busy, 1'b1);
            chk_i("start_count", n_start, starts0 + 1);
        end else begin
            chk_b("ferr_pulse", frame_err, 1'b1);
            chk_b("ferr_no_start", mont_start, 1'b0);
            chk_b("ferr_s_ready", s_ready, 1'b1);
            tick;
            chk_b("ferr_clears", frame_err, 1'b0);
            repeat (3) tick;
            chk_i("ferr_count", n_ferr, ferr0 + 1);
            chk_i("ferr_start_count", n_start, starts0);
            chk_b("ferr_busy", busy, 1'b0);
        end
    endtask

    // Stub completion: waits a little in WAIT, then pulses mont_done.
    task automatic finish_mult(input logic [1024:0] res);
        repeat (3) tick;
        chk_b("no_valid_in_wait", m_valid, 1'b0);
        mont_result = res;
        mont_done   = 1'b1;
        tick;
        mont_done   = 1'b0;
        chk_b("valid_after_done", m_valid, 1'b1);
    endtask

    // Collects 33 result words; toggle=1 alternates m_ready every cycle.
    task automatic recv_result(input logic [1024:0] res, input bit toggle);
        int j;
        int bud;
        bit rdy;
        bit hs;
        logic [31:0] ew;
        j = 0;
        bud = 200;
        rdy = 1'b1;
        while (j < 33 && bud > 0) begin
            ew = (j < 32) ? res[32*j +: 32] : {31'd0, res[1024]};
            m_ready = rdy;
            chk_b("m_valid", m_valid, 1'b1);
            chk_w("m_data", m_data, ew);
            chk_b("m_last", m_last, (j == 32));
            hs = (m_valid === 1'b1) && rdy;
            tick;
            if (hs) j++;
            if (toggle) rdy = ~rdy;
            bud--;
        end
        m_ready = 1'b0;
        if (j < 33) chk_i("stream_timeout", j, 33);
        chk_b("s_ready_after_stream", s_ready, 1'b1);
        chk_b("m_valid_after_stream", m_valid, 1'b0);
        chk_b("busy_after_stream", busy, 1'b0);
    endtask

    logic [1023:0] junk;
    logic [1023:0] xa;
    logic [1023:0] xb;
    logic [1023:0] xm;
    logic [1023:0] ya;
    logic [1024:0] res1;
    logic [1024:0] res2;
    logic [1024:0] resx;
    logic [1024:0] resy;

    initial begin
        resetn      = 1'b0;
        s_valid     = 1'b0;
        s_data      = 32'd0;
        s_last      = 1'b0;
        mont_result = 1025'd0;
        mont_done   = 1'b0;
        m_ready     = 1'b0;
        junk = {32{32'hCAFEF00D}};
        xa   = {32{32'h1234_5678}};
        xb   = {32{32'h9ABC_DEF0}};
        xm   = {32{32'h0F0F_F0F0}};
        ya   = {32{32'h5555_AAAA}};
        res1 = {1'b1, 1024'hDEADBEEF};
        res2 = {1'b0, {32{32'h0000_0001}}};
        resx = {1'b1, {16{64'h0123_4567_89AB_CDEF}}};
        resy = {1'b0, {32{32'hFEDC_BA98}}};
        repeat (2) tick;
        resetn = 1'b1;
        tick;

        // Reset values.
        chk_b("rst_s_ready", s_ready, 1'b1);
        chk_b("rst_mont_start", mont_start, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_m_valid", m_valid, 1'b0);
        chk_w("rst_m_data", m_data, 32'd0);
        chk_b("rst_m_last", m_last, 1'b0);
        chk_b("rst_frame_err", frame_err, 1'b0);
        chk_op("rst_mont_a", mont_a, 1024'd0);

        // Spurious done in LOAD is ignored.
        mont_result = res1;
        mont_done   = 1'b1;
        tick;
        mont_done   = 1'b0;
        tick;
        chk_b("spur_m_valid", m_valid, 1'b0);
        chk_b("spur_busy", busy, 1'b0);
        chk_b("spur_s_ready", s_ready, 1'b1);

        // Full gap-free frame, result streamed with toggling m_ready.
        send_frame(1024'h3, 1024'h5, 1024'hB, 95, 0);
        chk_op("f1_a", mont_a, 1024'h3);
        chk_op("f1_b", mont_b, 1024'h5);
        chk_op("f1_m", mont_m, 1024'hB);
        finish_mult(res1);
        recv_result(res1, 1'b1);
        chk_op("f1_a_stable", mont_a, 1024'h3);

        // Early s_last at word 50 pollutes A/B, then a gapped good frame.
        send_frame(junk, junk, junk, 50, 0);
        send_frame(1024'h3, 1024'h5, 1024'hB, 95, 7);
        chk_op("gap_a", mont_a, 1024'h3);
        chk_op("gap_b", mont_b, 1024'h5);
        chk_op("gap_m", mont_m, 1024'hB);
        finish_mult(res2);
        recv_result(res2, 1'b0);

        // Missing s_last on word 95.
        send_frame(junk, junk, junk, -1, 0);
        send_frame(1024'h7, 1024'h9, 1024'hD, 95, 0);
        chk_op("rec_a", mont_a, 1024'h7);
        chk_op("rec_m", mont_m, 1024'hD);

        // Reset for one cycle while in WAIT, then a late done.
        tick;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        chk_b("wrst_s_ready", s_ready, 1'b1);
        chk_b("wrst_mont_start", mont_start, 1'b0);
        chk_b("wrst_busy", busy, 1'b0);
        chk_b("wrst_m_valid", m_valid, 1'b0);
        chk_w("wrst_m_data", m_data, 32'd0);
        chk_b("wrst_m_last", m_last, 1'b0);
        chk_b("wrst_frame_err", frame_err, 1'b0);
        chk_op("wrst_mont_a", mont_a, 1024'd0);
        chk_op("wrst_mont_b", mont_b, 1024'd0);
        chk_op("wrst_mont_m", mont_m, 1024'd0);
        mont_result = res1;
        mont_done   = 1'b1;
        tick;
        mont_done   = 1'b0;
        chk_b("late_done_m_valid", m_valid, 1'b0);
        tick;
        chk_b("late_done_m_valid2", m_valid, 1'b0);
        chk_b("late_done_busy", busy, 1'b0);

        // Back-to-back frames.
        send_frame(xa, xb, xm, 95, 0);
        finish_mult(resx);
        recv_result(resx, 1'b1);
        send_frame(ya, xa, xb, 95, 0);
        chk_op("b2b_a", mont_a, ya);
        chk_op("b2b_b", mont_b, xa);
        chk_op("b2b_m", mont_m, xb);
        finish_mult(resy);
        recv_result(resy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
